gtrg_hdr_reader: RTL

//  Read-side consumer of the GTRG FIFO. Pops one stored trigger entry (DAV bits plus DMB/CFEB BX).

---
 rtl/gtrg_hdr_reader_pkg.sv | 38 +++
 rtl/gtrg_hdr_reader_if.sv | 22 ++
 rtl/cbnce.sv | 37 +++
 rtl/gtrg_hdr_reader_wordmux.sv | 41 ++++
 rtl/gtrg_hdr_reader.sv | 107 ++++++++++
 5 files changed

// File: rtl/gtrg_hdr_reader_pkg.sv
// Shared types and constants for the GTRG header reader.
// Build option: HDR_PARITY_EN appends a parity word to every header frame.
package gtrg_hdr_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_CAPT = 3'd2,
    ST_SEND = 3'd3,
    ST_GAP  = 3'd4
  } hdr_st_t;

  localparam logic [3:0] HDR_MRK_L1A = 4'h9;
  localparam logic [3:0] HDR_MRK_BX  = 4'hA;
  localparam logic [3:0] HDR_MRK_PAR = 4'hF;

`ifdef HDR_PARITY_EN
  localparam int HDR_WORDS = 5;
`else
  localparam int HDR_WORDS = 4;
`endif

  localparam int               IDX_W    = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDR_WORDS - 1);

  // One popped FIFO entry together with the event number it was tagged with.
  typedef struct packed {
    logic [16:0] dav;
    logic [11:0] bx;
    logic [3:0]  cfebbx;
    logic [23:0] l1a;
  } hdr_cap_t;

  function automatic hdr_st_t maj_st(input hdr_st_t a, input hdr_st_t b, input hdr_st_t c);
    return hdr_st_t'((a & b) | (a & c) | (b & c));
  endfunction

endpackage

// File: rtl/gtrg_hdr_reader_if.sv
// FIFO read port plus header stream toward the DMB readout formatter.
interface gtrg_hdr_reader_if;
  logic        EMPTY_B;
  logic [16:0] DAVSOUT;
  logic [11:0] BXCOUNTOUT;
  logic [3:0]  CFEBBX;
  logic        POP;
  logic [15:0] DOUT;
  logic        DVALID;
  logic        DREADY;
  logic        DLAST;

  modport master (
    input  EMPTY_B, DAVSOUT, BXCOUNTOUT, CFEBBX, DREADY,
    output POP, DOUT, DVALID, DLAST
  );

  modport slave (
    output EMPTY_B, DAVSOUT, BXCOUNTOUT, CFEBBX, DREADY,
    input  POP, DOUT, DVALID, DLAST
  );
endinterface

// File: rtl/cbnce.sv
// Clock-enabled binary up counter with sync clear and optional triplicated storage.
module cbnce #(
  parameter int Width = 24,
  parameter int TMR   = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             CE,
  output logic [Width-1:0] Q
);
  localparam int NCOPY = (TMR != 0) ? 3 : 1;

  logic [NCOPY-1:0][Width-1:0] r_q;
  logic [Width-1:0]            w_q;

  generate
    if (TMR != 0) begin : g_vote
      assign w_q = (r_q[0] & r_q[1]) | (r_q[0] & r_q[2]) | (r_q[1] & r_q[2]);
    end else begin : g_one
      assign w_q = r_q[0];
    end
  endgenerate

  // Every copy reloads from the voted value, so a single upset heals in one cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_q <= '0;
    end else begin
      for (int i = 0; i < NCOPY; i++) begin
        r_q[i] <= CLR ? '0 : (CE ? w_q + Width'(1) : w_q);
      end
    end
  end

  assign Q = w_q;
endmodule

// File: rtl/gtrg_hdr_reader_wordmux.sv
// Combinational header word selection from the captured entry and word index.
// Build option: HDR_PARITY_EN adds word 4 (XOR of the payloads of words 0-3).
module gtrg_hdr_wordmux
  import gtrg_hdr_reader_pkg::*;
(
  input  logic [IDX_W-1:0] i_idx,
  input  hdr_cap_t         i_cap,
  output logic [15:0]      o_word,
  output logic             o_last
);
  logic [15:0] w_w0, w_w1, w_w2, w_w3;

  assign w_w0 = {HDR_MRK_L1A, i_cap.l1a[11:0]};
  assign w_w1 = {HDR_MRK_L1A, i_cap.l1a[23:12]};
  assign w_w2 = {HDR_MRK_BX,  i_cap.bx};
  // MOVLP bits collapse to a single overlap flag; LCT bx bits are not carried.
  assign w_w3 = {HDR_MRK_BX, i_cap.cfebbx, i_cap.dav[16], i_cap.dav[0],
                 i_cap.dav[5:1], |i_cap.dav[10:6]};

  wire w_unused_lct = &{1'b0, i_cap.dav[15:11]};

`ifdef HDR_PARITY_EN
  logic [15:0] w_w4;
  assign w_w4 = {HDR_MRK_PAR, w_w0[11:0] ^ w_w1[11:0] ^ w_w2[11:0] ^ w_w3[11:0]};
`endif

  always_comb begin
    o_word = w_w0;
    case (i_idx)
      3'd1:    o_word = w_w1;
      3'd2:    o_word = w_w2;
      3'd3:    o_word = w_w3;
`ifdef HDR_PARITY_EN
      3'd4:    o_word = w_w4;
`endif
      default: o_word = w_w0;
    endcase
  end

  assign o_last = (i_idx == LAST_IDX);
endmodule

// File: rtl/gtrg_hdr_reader.sv
// Pops one GTRG FIFO entry per frame, tags it with the L1A number and streams a header.
// Build option: HDR_PARITY_EN selects the 5-word frame with trailing parity word.
module gtrg_hdr_reader
  import gtrg_hdr_reader_pkg::*;
#(
  parameter int TMR = 0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     L1ARST,
  gtrg_hdr_reader_if.master        HDR,
  output logic                     BUSY,
  output logic [23:0]              L1ACNT
);
  localparam int NCOPY = (TMR != 0) ? 3 : 1;

  hdr_st_t          r_st [NCOPY];
  hdr_st_t          w_st;
  logic [IDX_W-1:0] r_idx;
  logic             r_pop;
  logic             r_dvalid;
  logic             r_busy;
  hdr_cap_t         r_cap;
  logic [15:0]      w_word;
  logic             w_last;

  generate
    if (TMR != 0) begin : g_vote
      assign w_st = maj_st(r_st[0], r_st[1], r_st[2]);
    end else begin : g_one
      assign w_st = r_st[0];
    end
  endgenerate

  // The counter advances on the CAPT cycle, i.e. exactly when POP is high.
  cbnce #(.Width(24), .TMR(TMR)) u_l1a (
    .CLK (CLK),
    .RST (RST),
    .CLR (L1ARST),
    .CE  (r_pop),
    .Q   (L1ACNT)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_st     <= '{default: ST_IDLE};
      r_idx    <= '0;
      r_pop    <= 1'b0;
      r_dvalid <= 1'b0;
      r_busy   <= 1'b0;
      r_cap    <= '0;
    end else begin
      case (w_st)
        ST_IDLE: begin
          if (HDR.EMPTY_B) begin
            r_st   <= '{default: ST_ARM};
            r_busy <= 1'b1;
          end
        end
        ST_ARM: begin
          r_st  <= '{default: ST_CAPT};
          r_pop <= 1'b1;
        end
        ST_CAPT: begin
          r_cap    <= '{dav: HDR.DAVSOUT, bx: HDR.BXCOUNTOUT, cfebbx: HDR.CFEBBX, l1a: L1ACNT};
          r_idx    <= '0;
          r_pop    <= 1'b0;
          r_dvalid <= 1'b1;
          r_st     <= '{default: ST_SEND};
        end
        ST_SEND: begin
          if (HDR.DREADY) begin
            if (r_idx == LAST_IDX) begin
              r_dvalid <= 1'b0;
              r_st     <= '{default: ST_GAP};
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        ST_GAP: begin
          r_busy <= 1'b0;
          r_st   <= '{default: ST_IDLE};
        end
        default: begin
          r_pop    <= 1'b0;
          r_dvalid <= 1'b0;
          r_busy   <= 1'b0;
          r_st     <= '{default: ST_IDLE};
        end
      endcase
    end
  end

  gtrg_hdr_wordmux u_mux (
    .i_idx  (r_idx),
    .i_cap  (r_cap),
    .o_word (w_word),
    .o_last (w_last)
  );

  assign HDR.POP    = r_pop;
  assign HDR.DVALID = r_dvalid;
  assign HDR.DOUT   = r_dvalid ? w_word : 16'h0000;
  assign HDR.DLAST  = r_dvalid & w_last;
  assign BUSY       = r_busy;
endmodule
